// File: rtl/fp_pkg.sv
// Shared FP32 definitions: field widths, exponent bias, rounding modes,
// operand classes and the exception-flag bundle used by the FP converters.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    typedef enum logic {
        RM_TRUNC = 1'b0,
        RM_RNE   = 1'b1
    } round_mode_e;

    typedef enum logic [2:0] {
        FP_ZERO   = 3'd0,
        FP_DENORM = 3'd1,
        FP_NORMAL = 3'd2,
        FP_INF    = 3'd3,
        FP_NAN    = 3'd4
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 field split and operand classification.
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [31:0]         f,
    output logic                sign,
    output logic [FP_EXP_W-1:0] exp,
    output logic [FP_MAN_W-1:0] man,
    output fp_class_e           cls
);

    assign sign = f[31];
    assign exp  = f[30:23];
    assign man  = f[22:0];

    always_comb begin
        cls = FP_NORMAL;
        if (exp == {FP_EXP_W{1'b0}}) begin
            cls = (man == {FP_MAN_W{1'b0}}) ? FP_ZERO : FP_DENORM;
        end else if (exp == {FP_EXP_W{1'b1}}) begin
            cls = (man == {FP_MAN_W{1'b0}}) ? FP_INF : FP_NAN;
        end else begin
            cls = FP_NORMAL;
        end
    end

endmodule

// File: rtl/fp32_to_int_pipe.sv
// Three-stage FP32 -> signed INT_W converter with valid/ready handshake.
// Define FP2INT_ROUND_EN to honour round_mode (RNE); otherwise always truncates.
module fp32_to_int_pipe
    import fp_pkg::*;
#(
    parameter int INT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_float,
    input  logic             round_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic [3:0]       out_flags
);

    localparam logic [32:0] LIM_POS = (33'd1 << (INT_W - 1)) - 33'd1;
    localparam logic [32:0] LIM_NEG = 33'd1 << (INT_W - 1);
    localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};

    logic en_s;
    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    // ---------------- S1: unpack / classify ----------------
    logic                unp_sign_s;
    logic [FP_EXP_W-1:0] unp_exp_s;
    logic [FP_MAN_W-1:0] unp_man_s;
    fp_class_e           unp_cls_s;

    fp32_unpack u_unpack (
        .f    (in_float),
        .sign (unp_sign_s),
        .exp  (unp_exp_s),
        .man  (unp_man_s),
        .cls  (unp_cls_s)
    );

    logic        s1_valid_d, s1_valid_q;
    logic        s1_sign_d,  s1_sign_q;
    logic [8:0]  s1_e_d,     s1_e_q;
    logic [23:0] s1_mant_d,  s1_mant_q;
    fp_class_e   s1_cls_d,   s1_cls_q;
`ifdef FP2INT_ROUND_EN
    round_mode_e s1_rm_d, s1_rm_q, s2_rm_d, s2_rm_q;
`else
    logic unused_round_mode_s;
    assign unused_round_mode_s = round_mode;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_e_d     = s1_e_q;
        s1_mant_d  = s1_mant_q;
        s1_cls_d   = s1_cls_q;
`ifdef FP2INT_ROUND_EN
        s1_rm_d    = s1_rm_q;
`endif
        if (en_s) begin
            s1_valid_d = in_valid;
            s1_sign_d  = unp_sign_s;
            s1_e_d     = $signed({1'b0, unp_exp_s}) - $signed(9'(FP_BIAS));
            s1_mant_d  = {1'b1, unp_man_s};
            s1_cls_d   = unp_cls_s;
`ifdef FP2INT_ROUND_EN
            s1_rm_d    = round_mode_e'(round_mode);
`endif
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // ---------------- S2: align, guard, sticky ----------------
    // Fixed point with 32 fraction bits: integer part [63:32], guard [31].
    logic [8:0]  sh_s;
    logic [63:0] x_s;
    logic        big_s, tiny_s;

    logic        s2_valid_d,  s2_valid_q;
    logic        s2_sign_d,   s2_sign_q;
    fp_class_e   s2_cls_d,    s2_cls_q;
    logic        s2_big_d,    s2_big_q;
    logic [31:0] s2_mag_d,    s2_mag_q;
    logic        s2_guard_d,  s2_guard_q;
    logic        s2_sticky_d, s2_sticky_q;

    always_comb begin
        sh_s   = s1_e_q + 9'sd9;
        x_s    = {40'd0, s1_mant_q} << $unsigned(sh_s);
        big_s  = $signed(s1_e_q) >= $signed(9'(INT_W));
        tiny_s = $signed(s1_e_q) < -9'sd1;

        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_cls_d    = s2_cls_q;
        s2_big_d    = s2_big_q;
        s2_mag_d    = s2_mag_q;
        s2_guard_d  = s2_guard_q;
        s2_sticky_d = s2_sticky_q;
`ifdef FP2INT_ROUND_EN
        s2_rm_d     = s2_rm_q;
`endif
        if (en_s) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_cls_d   = s1_cls_q;
            s2_big_d   = big_s;
`ifdef FP2INT_ROUND_EN
            s2_rm_d    = s1_rm_q;
`endif
            if (tiny_s) begin
                s2_mag_d    = 32'd0;
                s2_guard_d  = 1'b0;
                s2_sticky_d = 1'b1;
            end else if (big_s) begin
                s2_mag_d    = 32'd0;
                s2_guard_d  = 1'b0;
                s2_sticky_d = 1'b0;
            end else begin
                s2_mag_d    = x_s[63:32];
                s2_guard_d  = x_s[31];
                s2_sticky_d = |x_s[30:0];
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // ---------------- S3: round, saturate, negate, flag ----------------
    logic [32:0]      rounded_s;
    logic [INT_W-1:0] mag_n_s;
    logic             ovf_s;
    logic             out_valid_d, out_valid_q;
    logic [INT_W-1:0] out_int_d,   out_int_q;
    fp_flags_t        out_flags_d, out_flags_q;

    always_comb begin
`ifdef FP2INT_ROUND_EN
        rounded_s = {1'b0, s2_mag_q} + {32'd0, (s2_rm_q == RM_RNE) && s2_guard_q
                                               && (s2_sticky_q || s2_mag_q[0])};
`else
        rounded_s = {1'b0, s2_mag_q};
`endif
        mag_n_s = rounded_s[INT_W-1:0];
        ovf_s   = s2_big_q || (s2_sign_q ? (rounded_s > LIM_NEG) : (rounded_s > LIM_POS));

        out_valid_d = out_valid_q;
        out_int_d   = out_int_q;
        out_flags_d = out_flags_q;
        if (en_s) begin
            out_valid_d = s2_valid_q;
            out_flags_d = '0;
            case (s2_cls_q)
                FP_NAN: begin
                    out_int_d           = SAT_POS;
                    out_flags_d.invalid = 1'b1;
                end
                FP_INF: begin
                    out_int_d            = s2_sign_q ? SAT_NEG : SAT_POS;
                    out_flags_d.overflow = 1'b1;
                end
                FP_ZERO: begin
                    out_int_d = {INT_W{1'b0}};
                end
                FP_DENORM: begin
                    out_int_d             = {INT_W{1'b0}};
                    out_flags_d.underflow = 1'b1;
                    out_flags_d.inexact   = 1'b1;
                end
                FP_NORMAL: begin
                    if (ovf_s) begin
                        out_int_d            = s2_sign_q ? SAT_NEG : SAT_POS;
                        out_flags_d.overflow = 1'b1;
                    end else begin
                        out_int_d             = s2_sign_q ? (~mag_n_s + {{(INT_W-1){1'b0}}, 1'b1}) : mag_n_s;
                        out_flags_d.underflow = (rounded_s == 33'd0);
                        out_flags_d.inexact   = s2_guard_q || s2_sticky_q;
                    end
                end
                default: begin
                    out_int_d           = SAT_POS;
                    out_flags_d.invalid = 1'b1;
                end
            endcase
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset drops all in-flight data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_e_q      <= 9'd0;
            s1_mant_q   <= 24'd0;
            s1_cls_q    <= FP_ZERO;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= FP_ZERO;
            s2_big_q    <= 1'b0;
            s2_mag_q    <= 32'd0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_int_q   <= {INT_W{1'b0}};
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_e_q      <= s1_e_d;
            s1_mant_q   <= s1_mant_d;
            s1_cls_q    <= s1_cls_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_cls_q    <= s2_cls_d;
            s2_big_q    <= s2_big_d;
            s2_mag_q    <= s2_mag_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            out_flags_q <= out_flags_d;
        end
    end

`ifdef FP2INT_ROUND_EN
    // Rounding-mode tags travel alongside their operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_rm_q <= RM_TRUNC;
            s2_rm_q <= RM_TRUNC;
        end else begin
            s1_rm_q <= s1_rm_d;
            s2_rm_q <= s2_rm_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_int   = out_int_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp32_to_int_pipe.sv
// Directed self-checking bench for fp32_to_int_pipe at INT_W = 8.
module tb_fp32_to_int_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic        round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_int;
    logic [3:0]  out_flags;

    int n_cmp = 0;
    int n_err = 0;

    fp32_to_int_pipe #(.INT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_float   (in_float),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_int    (out_int),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic convert(input string name, input logic [31:0] f, input logic rm,
                           input logic [7:0] exp_int, input logic [3:0] exp_flags,
                           input logic check_lat);
        int cnt;
        @(negedge clk);
        in_valid   = 1'b1;
        in_float   = f;
        round_mode = rm;
        out_ready  = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (check_lat) begin
            n_cmp++;
            if (cnt != 3) begin
                n_err++;
                $display("FAIL %s latency: got %0d want 3", name, cnt);
            end
        end
        n_cmp++;
        if (out_int !== exp_int || out_flags !== exp_flags || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s result: got int=%h flags=%b valid=%b want int=%h flags=%b",
                     name, out_int, out_flags, out_valid, exp_int, exp_flags);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_int !== 8'h00 || out_flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: got v=%b int=%h flags=%b want 0/00/0000",
                     out_valid, out_int, out_flags);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        convert("pos127", 32'h42FE0000, 1'b0, 8'h7F, 4'b0000, 1'b1);
        convert("neg128", 32'hC3000000, 1'b0, 8'h80, 4'b0000, 1'b1);
        convert("pos128_ovf", 32'h43000000, 1'b0, 8'h7F, 4'b0100, 1'b0);
        convert("neg_inf", 32'hFF800000, 1'b0, 8'h80, 4'b0100, 1'b0);
        convert("pos_inf", 32'h7F800000, 1'b0, 8'h7F, 4'b0100, 1'b0);
        convert("nan", 32'h7FC00000, 1'b0, 8'h7F, 4'b1000, 1'b0);
        convert("neg_zero", 32'h80000000, 1'b0, 8'h00, 4'b0000, 1'b0);
        convert("denorm", 32'h00000001, 1'b0, 8'h00, 4'b0011, 1'b0);
        convert("neg100", 32'hC2C80000, 1'b0, 8'h9C, 4'b0000, 1'b0);
    endtask

    task automatic test_rounding();
        convert("trunc_1p5", 32'h3FC00000, 1'b0, 8'h01, 4'b0001, 1'b0);
        convert("trunc_m1p5", 32'hBFC00000, 1'b0, 8'hFF, 4'b0001, 1'b0);
        convert("trunc_0p5", 32'h3F000000, 1'b0, 8'h00, 4'b0011, 1'b0);
`ifdef FP2INT_ROUND_EN
        convert("rne_1p5", 32'h3FC00000, 1'b1, 8'h02, 4'b0001, 1'b0);
        convert("rne_2p5", 32'h40200000, 1'b1, 8'h02, 4'b0001, 1'b0);
        convert("rne_0p5", 32'h3F000000, 1'b1, 8'h00, 4'b0011, 1'b0);
        convert("rne_127p5", 32'h42FF0000, 1'b1, 8'h7F, 4'b0100, 1'b0);
`else
        convert("rm_ignored_1p5", 32'h3FC00000, 1'b1, 8'h01, 4'b0001, 1'b0);
        convert("rm_ignored_2p5", 32'h40200000, 1'b1, 8'h02, 4'b0001, 1'b0);
        convert("rm_ignored_0p5", 32'h3F000000, 1'b1, 8'h00, 4'b0011, 1'b0);
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] vin  [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                   32'h40800000, 32'h40A00000, 32'hBF800000};
        logic [7:0]  vexp [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};
        int sent = 0;
        int got  = 0;
        int acc_in_stall = 0;
        logic acc, take;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            in_valid   = (sent < 6);
            in_float   = (sent < 6) ? vin[sent] : 32'h0;
            round_mode = 1'b0;
            out_ready  = (cyc >= 5);
            #1;
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (cyc < 5 && acc) acc_in_stall++;
            if (cyc == 4) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_int !== 8'h01) begin
                    n_err++;
                    $display("FAIL bp_stall_hold: got rdy=%b v=%b int=%h want 0/1/01",
                             in_ready, out_valid, out_int);
                end
            end
            if (take) begin
                n_cmp++;
                if (out_int !== vexp[got] || out_flags !== 4'b0000) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got int=%h flags=%b want %h/0000",
                             got, out_int, out_flags, vexp[got]);
                end
                got++;
            end
            if (acc) sent++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (acc_in_stall != 3) begin
            n_err++;
            $display("FAIL bp_accept_count: got %0d want 3", acc_in_stall);
        end
        n_cmp++;
        if (got != 6) begin
            n_err++;
            $display("FAIL bp_received: got %0d want 6", got);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        logic stale = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_float = 32'h40A00000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_int !== 8'h00 || out_flags !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_clear: got v=%b int=%h flags=%b want 0/00/0000",
                     out_valid, out_int, out_flags);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) stale = 1'b1;
        end
        n_cmp++;
        if (stale) begin
            n_err++;
            $display("FAIL midreset_stale: got stale result want none");
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_float   = 32'h0;
        round_mode = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_rounding();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
